// File: rtl/output_channel_buffer_array.sv
// ---------------------------------------------------------------------------
// output_channel_buffer_array
//
// Purpose:
//   A bank of small, independent FIFOs, one for each output channel. It sits
//   between the PE writeback stage and the interconnect. A writeback word is
//   enqueued into every channel whose bit is set in the writeback OCI mask.
//   Each channel then drains its head entry to the network over its own
//   valid/ready handshake.
//
//   The per-channel full status is decoded from registered state only. The
//   trigger stage can therefore consume it without creating a combinational
//   loop back through writeback_oci or output_channel_ready.
//
// Ports:
//   clock                       sole clock; all state updates on rising edge
//   reset                       synchronous, active-high; discards all contents
//   writeback_oci               bit i set -> enqueue {tag,data} to channel i
//   writeback_tag               tag enqueued to every selected channel
//   writeback_data              data enqueued to every selected channel
//   output_channel_valid        channel i head entry valid
//   output_channel_tag          head tags, channel i at [i*TAG_WIDTH +: TAG_WIDTH]
//   output_channel_data         head data, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   output_channel_ready        network accepts channel i head this cycle
//   output_channel_full_status  channel i holds DEPTH entries
//   output_channel_overflow     sticky; a write to channel i was dropped
// ---------------------------------------------------------------------------
module output_channel_buffer_array #(
  parameter int NUM_OUTPUT_CHANNELS = 4,
  parameter int WORD_WIDTH          = 32,
  parameter int TAG_WIDTH           = 3,
  parameter int DEPTH               = 2
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]            writeback_oci,
  input  logic [TAG_WIDTH-1:0]                      writeback_tag,
  input  logic [WORD_WIDTH-1:0]                     writeback_data,
  output logic [NUM_OUTPUT_CHANNELS-1:0]            output_channel_valid,
  output logic [NUM_OUTPUT_CHANNELS*TAG_WIDTH-1:0]  output_channel_tag,
  output logic [NUM_OUTPUT_CHANNELS*WORD_WIDTH-1:0] output_channel_data,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]            output_channel_ready,
  output logic [NUM_OUTPUT_CHANNELS-1:0]            output_channel_full_status,
  output logic [NUM_OUTPUT_CHANNELS-1:0]            output_channel_overflow
);

  // A stored entry packs the tag above the data word.
  localparam int ENTRY_WIDTH = TAG_WIDTH + WORD_WIDTH;

  // Pointers need at least one bit, even when DEPTH is 1.
  localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COUNT_WIDTH = $clog2(DEPTH + 1);

  localparam logic [PTR_WIDTH-1:0]   LAST_SLOT  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] ONE_COUNT  = COUNT_WIDTH'(1);

  // DEPTH need not be a power of two. Pointers therefore wrap explicitly
  // instead of relying on natural binary rollover.
  function automatic logic [PTR_WIDTH-1:0] advance_ptr(input logic [PTR_WIDTH-1:0] ptr);
    if (ptr == LAST_SLOT) begin
      return '0;
    end
    return ptr + PTR_WIDTH'(1);
  endfunction

  genvar ch;
  generate
    for (ch = 0; ch < NUM_OUTPUT_CHANNELS; ch++) begin : g_channel

      logic [ENTRY_WIDTH-1:0] storage [DEPTH];

      logic [PTR_WIDTH-1:0]   head;
      logic [PTR_WIDTH-1:0]   tail;
      logic [PTR_WIDTH-1:0]   head_next;
      logic [PTR_WIDTH-1:0]   tail_next;
      logic [COUNT_WIDTH-1:0] count;
      logic [COUNT_WIDTH-1:0] count_next;
      logic                   overflow;
      logic                   overflow_next;

      logic                   is_valid;
      logic                   is_full;
      logic                   dequeue;
      logic                   enqueue_request;
      logic                   enqueue_accept;
      logic                   enqueue_drop;
      logic [ENTRY_WIDTH-1:0] head_entry;

      // Status is a pure decode of the registered count. Nothing here looks at
      // writeback_oci or ready, so the trigger stage sees a clean registered
      // signal.
      assign is_valid = (count != '0);
      assign is_full  = (count == FULL_COUNT);

      // A full channel can still take a write when its head leaves in the same
      // cycle. The slot being freed is the one the new word reuses, so the
      // count holds at DEPTH and nothing is lost.
      assign dequeue         = is_valid & output_channel_ready[ch];
      assign enqueue_request = writeback_oci[ch];
      assign enqueue_accept  = enqueue_request & (~is_full | dequeue);
      assign enqueue_drop    = enqueue_request & ~enqueue_accept;

      // Next-state logic for the pointers, the occupancy count and the sticky
      // overflow flag. A dropped write changes nothing except the overflow flag.
      always_comb begin
        head_next     = head;
        tail_next     = tail;
        count_next    = count;
        overflow_next = overflow | enqueue_drop;

        if (dequeue) begin
          head_next = advance_ptr(head);
        end
        if (enqueue_accept) begin
          tail_next = advance_ptr(tail);
        end

        unique case ({enqueue_accept, dequeue})
          2'b10:   count_next = count + ONE_COUNT;
          2'b01:   count_next = count - ONE_COUNT;
          default: count_next = count;
        endcase
      end

      // Control state register. Reset has priority over any simultaneous
      // enqueue or dequeue, and it empties the channel without touching
      // storage.
      always_ff @(posedge clock) begin
        if (reset) begin
          head     <= '0;
          tail     <= '0;
          count    <= '0;
          overflow <= 1'b0;
        end else begin
          head     <= head_next;
          tail     <= tail_next;
          count    <= count_next;
          overflow <= overflow_next;
        end
      end

      // Entry storage is left unreset because a stale entry is never visible.
      // Valid drops to 0 and the head is only ever read behind a valid count.
      // The write is suppressed during reset so that the write stays consistent
      // with the pointers being cleared.
      always_ff @(posedge clock) begin
        if (!reset && enqueue_accept) begin
          storage[tail] <= {writeback_tag, writeback_data};
        end
      end

      // The head entry is presented combinationally from storage. A freshly
      // written word therefore appears one cycle after it is enqueued, and
      // there is no bypass from writeback.
      assign head_entry = storage[head];

      assign output_channel_valid[ch]                          = is_valid;
      assign output_channel_full_status[ch]                    = is_full;
      assign output_channel_overflow[ch]                       = overflow;
      assign output_channel_tag[ch*TAG_WIDTH +: TAG_WIDTH]     = head_entry[ENTRY_WIDTH-1 -: TAG_WIDTH];
      assign output_channel_data[ch*WORD_WIDTH +: WORD_WIDTH]  = head_entry[WORD_WIDTH-1:0];

    end
  endgenerate

endmodule

// File: tb/tb_output_channel_buffer_array.sv
// ---------------------------------------------------------------------------
// tb_output_channel_buffer_array
//
// Testbench for output_channel_buffer_array with 4 channels, DEPTH=2,
// 32-bit words and 3-bit tags. It drives a table of directed vectors with
// hand-computed expected results. After the table it runs a streaming sequence
// on channel 0 in which the pointers wrap.
// ---------------------------------------------------------------------------
module tb_output_channel_buffer_array;

  localparam int NCH = 4;
  localparam int WW  = 32;
  localparam int TW  = 3;
  localparam int DEP = 2;

  logic              clock;
  logic              reset;
  logic [NCH-1:0]    writeback_oci;
  logic [TW-1:0]     writeback_tag;
  logic [WW-1:0]     writeback_data;
  logic [NCH-1:0]    output_channel_valid;
  logic [NCH*TW-1:0] output_channel_tag;
  logic [NCH*WW-1:0] output_channel_data;
  logic [NCH-1:0]    output_channel_ready;
  logic [NCH-1:0]    output_channel_full_status;
  logic [NCH-1:0]    output_channel_overflow;

  int total = 0;
  int bad   = 0;

  output_channel_buffer_array #(
    .NUM_OUTPUT_CHANNELS(NCH),
    .WORD_WIDTH(WW),
    .TAG_WIDTH(TW),
    .DEPTH(DEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .writeback_oci(writeback_oci),
    .writeback_tag(writeback_tag),
    .writeback_data(writeback_data),
    .output_channel_valid(output_channel_valid),
    .output_channel_tag(output_channel_tag),
    .output_channel_data(output_channel_data),
    .output_channel_ready(output_channel_ready),
    .output_channel_full_status(output_channel_full_status),
    .output_channel_overflow(output_channel_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A vector holds the inputs applied before one rising edge, followed by the
  // state expected just after that edge. When chk_ch is -1, the head tag and
  // data are not checked.
  typedef struct {
    logic          rst;
    logic [3:0]    oci;
    logic [2:0]    tag;
    logic [31:0]   data;
    logic [3:0]    rdy;
    logic [3:0]    exp_valid;
    logic [3:0]    exp_full;
    logic [3:0]    exp_ovf;
    int            chk_ch;
    logic [2:0]    exp_tag;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [3:0] oci, logic [2:0] tag, logic [31:0] data,
                              logic [3:0] rdy, logic [3:0] ev, logic [3:0] ef, logic [3:0] eo,
                              int cc, logic [2:0] et, logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.oci = oci; v.tag = tag; v.data = data; v.rdy = rdy;
    v.exp_valid = ev; v.exp_full = ef; v.exp_ovf = eo;
    v.chk_ch = cc; v.exp_tag = et; v.exp_data = ed;
    return v;
  endfunction

  // Inputs are driven 1 time unit after an edge. The task then advances to 1
  // time unit after the next edge, where the registered outputs are stable
  // for sampling.
  task automatic applyStimulus(input logic rst, input logic [3:0] oci, input logic [2:0] tag,
                               input logic [31:0] data, input logic [3:0] rdy);
    reset                = rst;
    writeback_oci        = oci;
    writeback_tag        = tag;
    writeback_data       = data;
    output_channel_ready = rdy;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [2:0] head_tag(int c);
    return output_channel_tag[c*TW +: TW];
  endfunction

  function automatic logic [31:0] head_data(int c);
    return output_channel_data[c*WW +: WW];
  endfunction

  // Safety net so that the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Bench-side model for the wrap stream on channel 0.
    logic [31:0] exp_q[$];
    logic [2:0]  exp_tq[$];
    int          cnt;
    int          sent;
    int          popped;
    int          cycles;
    logic        rdy;
    logic        deq;
    logic        enq;

    reset = 1'b1; writeback_oci = '0; writeback_tag = '0; writeback_data = '0;
    output_channel_ready = '0;
    @(posedge clock);
    #1;

    //               rst  oci    tag   data          rdy    valid  full   ovf   ch  tag   data
    // Reset, then idle.
    vecs.push_back(mk(1, 4'h0, 3'd0, 32'h0,        4'h0, 4'h0, 4'h0, 4'h0, -1, 3'd0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h0, 4'h0, 4'h0, 4'h0, -1, 3'd0, 32'h0));
    // Channel 0: the first write is visible next cycle, the second makes it full.
    vecs.push_back(mk(0, 4'h1, 3'd3, 32'hA5A5A5A5, 4'h0, 4'h1, 4'h0, 4'h0,  0, 3'd3, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 4'h1, 3'd1, 32'h1,        4'h0, 4'h1, 4'h1, 4'h0,  0, 3'd3, 32'hA5A5A5A5));
    // Fill channel 1, then reset with a write pending: everything is discarded.
    vecs.push_back(mk(0, 4'h2, 3'd2, 32'h20,       4'h0, 4'h3, 4'h1, 4'h0,  1, 3'd2, 32'h20));
    vecs.push_back(mk(0, 4'h2, 3'd2, 32'h21,       4'h0, 4'h3, 4'h3, 4'h0,  1, 3'd2, 32'h20));
    vecs.push_back(mk(1, 4'h2, 3'd2, 32'h22,       4'h0, 4'h0, 4'h0, 4'h0, -1, 3'd0, 32'h0));
    // Channel 2: fill, then dequeue and enqueue in the same cycle while full.
    vecs.push_back(mk(0, 4'h4, 3'd0, 32'h10,       4'h0, 4'h4, 4'h0, 4'h0,  2, 3'd0, 32'h10));
    vecs.push_back(mk(0, 4'h4, 3'd1, 32'h11,       4'h0, 4'h4, 4'h4, 4'h0,  2, 3'd0, 32'h10));
    vecs.push_back(mk(0, 4'h4, 3'd2, 32'h12,       4'h4, 4'h4, 4'h4, 4'h0,  2, 3'd1, 32'h11));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h4, 4'h4, 4'h0, 4'h0,  2, 3'd2, 32'h12));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h4, 4'h0, 4'h0, 4'h0, -1, 3'd0, 32'h0));
    // Channel 3: fill, a dropped write sets sticky overflow, and the drain
    // returns only the original two words.
    vecs.push_back(mk(0, 4'h8, 3'd6, 32'h30,       4'h0, 4'h8, 4'h0, 4'h0,  3, 3'd6, 32'h30));
    vecs.push_back(mk(0, 4'h8, 3'd7, 32'h31,       4'h0, 4'h8, 4'h8, 4'h0,  3, 3'd6, 32'h30));
    vecs.push_back(mk(0, 4'h8, 3'd4, 32'hDEAD,     4'h0, 4'h8, 4'h8, 4'h8,  3, 3'd6, 32'h30));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h8, 4'h8, 4'h0, 4'h8,  3, 3'd7, 32'h31));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h8, 4'h0, 4'h0, 4'h8, -1, 3'd0, 32'h0));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h8, 4'h0, 4'h0, 4'h8, -1, 3'd0, 32'h0));
    // Multi-hot write with channel 0 full: only channel 0 drops the word.
    vecs.push_back(mk(1, 4'h0, 3'd0, 32'h0,        4'h0, 4'h0, 4'h0, 4'h0, -1, 3'd0, 32'h0));
    vecs.push_back(mk(0, 4'h1, 3'd1, 32'h40,       4'h0, 4'h1, 4'h0, 4'h0,  0, 3'd1, 32'h40));
    vecs.push_back(mk(0, 4'h1, 3'd2, 32'h41,       4'h0, 4'h1, 4'h1, 4'h0,  0, 3'd1, 32'h40));
    vecs.push_back(mk(0, 4'hF, 3'd5, 32'h7,        4'h0, 4'hF, 4'h1, 4'h1,  1, 3'd5, 32'h7));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h0, 4'hF, 4'h1, 4'h1,  3, 3'd5, 32'h7));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h0, 4'hF, 4'h1, 4'h1,  2, 3'd5, 32'h7));
    vecs.push_back(mk(0, 4'h0, 3'd0, 32'h0,        4'h0, 4'hF, 4'h1, 4'h1,  0, 3'd1, 32'h40));

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].oci, vecs[k].tag, vecs[k].data, vecs[k].rdy);
      checkOutput($sformatf("vec%0d_valid", k), 32'(output_channel_valid), 32'(vecs[k].exp_valid));
      checkOutput($sformatf("vec%0d_full", k), 32'(output_channel_full_status), 32'(vecs[k].exp_full));
      checkOutput($sformatf("vec%0d_ovf", k), 32'(output_channel_overflow), 32'(vecs[k].exp_ovf));
      if (vecs[k].chk_ch >= 0) begin
        checkOutput($sformatf("vec%0d_tag_ch%0d", k, vecs[k].chk_ch),
                    32'(head_tag(vecs[k].chk_ch)), 32'(vecs[k].exp_tag));
        checkOutput($sformatf("vec%0d_data_ch%0d", k, vecs[k].chk_ch),
                    head_data(vecs[k].chk_ch), vecs[k].exp_data);
      end
    end

    // Wrap stream on channel 0: seven words with ready toggling 1,0,1,...
    // A word is offered only when the model says that it will be accepted.
    // The drained order must therefore match the written order exactly.
    applyStimulus(1'b1, 4'h0, 3'd0, 32'h0, 4'h0);
    cnt = 0; sent = 0; popped = 0; cycles = 0;
    while ((sent < 7 || cnt > 0) && cycles < 40) begin
      checkOutput($sformatf("wrap%0d_valid", cycles), 32'(output_channel_valid[0]), 32'(cnt > 0));
      checkOutput($sformatf("wrap%0d_full", cycles), 32'(output_channel_full_status[0]), 32'(cnt == DEP));
      rdy = (cycles % 2 == 0);
      deq = (cnt > 0) && rdy;
      if (deq) begin
        checkOutput($sformatf("wrap%0d_data", cycles), head_data(0), exp_q[0]);
        checkOutput($sformatf("wrap%0d_tag", cycles), 32'(head_tag(0)), 32'(exp_tq[0]));
        void'(exp_q.pop_front());
        void'(exp_tq.pop_front());
        popped++;
        cnt--;
      end
      enq = (sent < 7) && ((cnt + (deq ? 1 : 0)) < DEP || deq);
      if (enq) begin
        exp_q.push_back(32'h100 + 32'(sent));
        exp_tq.push_back(3'(sent));
        cnt++;
      end
      applyStimulus(1'b0, {3'b000, enq}, enq ? 3'(sent) : 3'd0,
                    enq ? 32'h100 + 32'(sent) : 32'h0, {3'b000, rdy});
      if (enq) sent++;
      cycles++;
    end
    checkOutput("wrap_popped", 32'(popped), 32'd7);
    checkOutput("wrap_ovf", 32'(output_channel_overflow), 32'h0);
    checkOutput("wrap_empty", 32'(output_channel_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
